// File: rtl/decoder_pkg.sv
// Shared RV32I definitions used by both the instruction decoder and the streaming encoder.
// Holds the opcode set, the encoder request kinds and a signed-range helper.
package decoder_pkg;

    typedef logic [31:0] word;
    typedef logic [4:0]  r;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_ALUI   = 7'b0010011,
        OP_SYSTEM = 7'b1110011
    } op_t;

    typedef enum logic [3:0] {
        ENC_LUI,
        ENC_AUIPC,
        ENC_JAL,
        ENC_JALR,
        ENC_BRANCH,
        ENC_ALUI,
        ENC_SYSTEM,
        ENC_LI
    } enc_kind_t;

    // True when v survives truncation to a two's-complement field of the given width.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] top;
        top = 32'($signed(v) >>> (bits - 1));
        return (top == '0) || (top == '1);
    endfunction

endpackage

// File: rtl/instr_format.sv
// Combinational RV32I field packer: lays out one instruction word from its fields and
// flags immediates that do not fit (or are misaligned for) the chosen format.
module instr_format
    import decoder_pkg::*;
(
    input  op_t        op_i,
    input  r           rd_i,
    input  r           rs1_i,
    input  r           rs2_i,
    input  logic [2:0] funct3_i,
    input  word        imm_i,
    output word        instr_o,
    output logic       range_err_o
);

    always_comb begin
        instr_o     = '0;
        range_err_o = 1'b0;
        unique case (op_i)
            OP_LUI, OP_AUIPC: begin
                instr_o     = {imm_i[31:12], rd_i, op_i};
                range_err_o = (imm_i[11:0] != 12'h000);
            end
            OP_JAL: begin
                instr_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                range_err_o = !fits_signed(imm_i, 21) || imm_i[0];
            end
            OP_JALR: begin
                instr_o     = {imm_i[11:0], rs1_i, 3'b000, rd_i, op_i};
                range_err_o = !fits_signed(imm_i, 12);
            end
            OP_BRANCH: begin
                instr_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], op_i};
                range_err_o = !fits_signed(imm_i, 13) || imm_i[0];
            end
            OP_ALUI, OP_SYSTEM: begin
                instr_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                range_err_o = !fits_signed(imm_i, 12);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: accepts instruction fields, emits registered instruction words with
// sequential addresses, and expands the li pseudo-instruction into lui (+ addi).
module instr_encoder
    import decoder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  enc_kind_t             in_kind,
    input  r                      in_rd,
    input  r                      in_rs1,
    input  r                      in_rs2,
    input  logic [2:0]            in_funct3,
    input  word                   in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output word                   out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err
);

    localparam logic [0:0] S_ONE = 1'b0;
    localparam logic [0:0] S_LI2 = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

    logic [0:0]            state_q, state_d;
    r                      hold_rd_q, hold_rd_d;
    logic [11:0]           hold_imm_q, hold_imm_d;
    logic                  out_valid_q, out_valid_d;
    word                   out_instr_q, out_instr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d;

    logic        in_fire, out_fire;
    logic        li_fits, li_two;
    logic [19:0] li_upper;

    op_t        fmt_op;
    r           fmt_rd, fmt_rs1, fmt_rs2;
    logic [2:0] fmt_f3;
    word        fmt_imm, fmt_word;
    logic       fmt_err;

    assign in_ready = !reset && (state_q == S_ONE) && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // Rounded upper part so that the sign-extended addi of imm[11:0] lands on the full value.
    assign li_fits  = fits_signed(in_imm, 12);
    assign li_upper = in_imm[31:12] + {19'b0, in_imm[11]};
    assign li_two   = !li_fits && (in_imm[11:0] != 12'h000);

    always_comb begin
        fmt_op  = OP_ALUI;
        fmt_rd  = in_rd;
        fmt_rs1 = in_rs1;
        fmt_rs2 = '0;
        fmt_f3  = in_funct3;
        fmt_imm = in_imm;
        if (state_q == S_LI2) begin
            fmt_rs1 = hold_rd_q;
            fmt_rd  = hold_rd_q;
            fmt_f3  = 3'b000;
            fmt_imm = {{20{hold_imm_q[11]}}, hold_imm_q};
        end else begin
            unique case (in_kind)
                ENC_LUI:    fmt_op = OP_LUI;
                ENC_AUIPC:  fmt_op = OP_AUIPC;
                ENC_JAL:    fmt_op = OP_JAL;
                ENC_JALR:   fmt_op = OP_JALR;
                ENC_BRANCH: begin
                    fmt_op  = OP_BRANCH;
                    fmt_rs2 = in_rs2;
                end
                ENC_ALUI:   fmt_op = OP_ALUI;
                ENC_SYSTEM: fmt_op = OP_SYSTEM;
                ENC_LI: begin
                    fmt_f3 = 3'b000;
                    if (li_fits) begin
                        fmt_op  = OP_ALUI;
                        fmt_rs1 = '0;
                    end else begin
                        fmt_op  = OP_LUI;
                        fmt_imm = {li_upper, 12'h000};
                    end
                end
                default: ;
            endcase
        end
    end

    instr_format u_format (
        .op_i        (fmt_op),
        .rd_i        (fmt_rd),
        .rs1_i       (fmt_rs1),
        .rs2_i       (fmt_rs2),
        .funct3_i    (fmt_f3),
        .imm_i       (fmt_imm),
        .instr_o     (fmt_word),
        .range_err_o (fmt_err)
    );

    always_comb begin
        state_d     = state_q;
        hold_rd_d   = hold_rd_q;
        hold_imm_d  = hold_imm_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        addr_d      = addr_q;
        err_d       = err_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + ADDR_WIDTH'(1);
        end

        if (state_q == S_LI2) begin
            if (out_fire) begin
                out_valid_d = 1'b1;
                out_instr_d = fmt_word;
                state_d     = S_ONE;
            end
        end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_instr_d = fmt_word;
            err_d       = err_q | fmt_err;
            if ((in_kind == ENC_LI) && li_two) begin
                state_d    = S_LI2;
                hold_rd_d  = in_rd;
                hold_imm_d = in_imm[11:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_ONE;
            hold_rd_q   <= '0;
            hold_imm_q  <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            addr_q      <= BaseAddr;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_rd_q   <= hold_rd_d;
            hold_imm_q  <= hold_imm_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = addr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of field vectors with hand-encoded expected words, a
// scoreboard queue checked on every output handshake, plus backpressure and reset sequences.
module tb_instr_encoder;
    import decoder_pkg::*;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      in_valid = 1'b0;
    logic      in_ready;
    enc_kind_t in_kind = ENC_ALUI;
    r          in_rd = '0;
    r          in_rs1 = '0;
    r          in_rs2 = '0;
    logic [2:0] in_funct3 = '0;
    word       in_imm = '0;
    logic      out_valid;
    logic      out_ready;
    word       out_instr;
    logic [9:0] out_addr;
    logic      err;

    instr_encoder #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        logic       rst;
        enc_kind_t  kind;
        r           rd;
        r           rs1;
        r           rs2;
        logic [2:0] f3;
        word        imm;
        int         n;
        word        w0;
        word        w1;
        logic       e;
    } vec_t;

    exp_t       sb[$];
    vec_t       tbl[$];
    int         checks = 0;
    int         errors = 0;
    int         ready_mode = 0;
    logic       sticky = 1'b0;
    logic [9:0] exp_addr = '0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // 0: always ready, 1: random backpressure, 2: stalled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_addr = '0;
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h at %0d expected none", out_instr,
                         out_addr);
            end else begin
                e = sb.pop_front();
                check("out_instr", out_instr, e.instr);
                check("out_addr", 32'(out_addr), 32'(exp_addr));
                check("err", 32'(err), 32'(e.err));
                exp_addr = exp_addr + 10'd1;
            end
        end
    end

    task automatic add(input logic rst_b, input enc_kind_t k, input r rd_v, input r rs1_v,
                       input r rs2_v, input logic [2:0] f3_v, input word imm_v, input int n_v,
                       input word w0_v, input word w1_v, input logic e_v);
        vec_t v;
        v.rst = rst_b;  v.kind = k;   v.rd = rd_v; v.rs1 = rs1_v; v.rs2 = rs2_v;
        v.f3 = f3_v;    v.imm = imm_v; v.n = n_v;  v.w0 = w0_v;   v.w1 = w1_v;
        v.e = e_v;
        tbl.push_back(v);
    endtask

    task automatic set_mode(input int m);
        ready_mode = m;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        bit   ok = 1'b0;
        in_kind = v.kind; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_imm = v.imm; in_valid = 1'b1;
        sticky  = sticky | v.e;
        e.instr = v.w0;
        e.err   = sticky;
        sb.push_back(e);
        if (v.n == 2) begin
            e.instr = v.w1;
            sb.push_back(e);
        end
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        end else begin
            check("latency_valid", 32'(out_valid), 32'd1);
            check("latency_instr", out_instr, v.w0);
        end
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(posedge clk);
            #2;
            c++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        drain();
        reset  = 1'b1;
        sticky = 1'b0;
        sb.delete();
        @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        bit stray;
        //   rst kind        rd  rs1 rs2 f3    imm           n  w0            w1            e
        add(0, ENC_ALUI,   1,  0,  0, 3'd0, 32'h00000005, 1, 32'h00500093, 32'h0, 0);
        add(0, ENC_LI,     5,  0,  0, 3'd0, 32'h12345678, 2, 32'h123452B7, 32'h67828293, 0);
        add(0, ENC_LI,     1,  0,  0, 3'd0, 32'hFFFFF800, 1, 32'h80000093, 32'h0, 0);
        add(0, ENC_LI,     1,  0,  0, 3'd0, 32'h00000800, 2, 32'h000010B7, 32'h80008093, 0);
        add(0, ENC_LI,     3,  0,  0, 3'd0, 32'h00005000, 1, 32'h000051B7, 32'h0, 0);
        add(0, ENC_LUI,    2,  7,  9, 3'd7, 32'hABCDE000, 1, 32'hABCDE137, 32'h0, 0);
        add(0, ENC_AUIPC,  4,  0,  0, 3'd0, 32'h00001000, 1, 32'h00001217, 32'h0, 0);
        add(0, ENC_JAL,    1,  0,  0, 3'd0, 32'h00000800, 1, 32'h001000EF, 32'h0, 0);
        add(0, ENC_JALR,   1,  2,  4, 3'd5, 32'hFFFFFFFC, 1, 32'hFFC100E7, 32'h0, 0);
        add(0, ENC_SYSTEM, 5,  6,  0, 3'd1, 32'h00000300, 1, 32'h300312F3, 32'h0, 0);
        add(0, ENC_BRANCH, 0,  1,  2, 3'd0, 32'h00000008, 1, 32'h00208463, 32'h0, 0);
        add(0, ENC_BRANCH, 0,  1,  2, 3'd1, 32'hFFFFFFFC, 1, 32'hFE209EE3, 32'h0, 0);
        add(0, ENC_ALUI,  10, 11,  3, 3'd7, 32'hFFFFFFFF, 1, 32'hFFF5F513, 32'h0, 0);
        add(0, ENC_LI,     6,  0,  0, 3'd0, 32'hFFFFFFFF, 1, 32'hFFF00313, 32'h0, 0);
        add(0, ENC_LI,     7,  0,  0, 3'd0, 32'h7FFFFFFF, 2, 32'h800003B7, 32'hFFF38393, 0);
        add(0, ENC_BRANCH, 0,  1,  2, 3'd0, 32'h00000007, 1, 32'h00208363, 32'h0, 1);
        add(0, ENC_ALUI,   1,  0,  0, 3'd0, 32'h00000001, 1, 32'h00100093, 32'h0, 0);
        add(1, ENC_LUI,    1,  0,  0, 3'd0, 32'h00001123, 1, 32'h000010B7, 32'h0, 1);
        add(1, ENC_JAL,    0,  0,  0, 3'd0, 32'h00000003, 1, 32'h0020006F, 32'h0, 1);
        add(1, ENC_ALUI,   1,  0,  0, 3'd0, 32'h00000800, 1, 32'h80000093, 32'h0, 1);
        add(1, ENC_JAL,    1,  0,  0, 3'd0, 32'h00100000, 1, 32'h800000EF, 32'h0, 1);
        add(1, ENC_BRANCH, 0,  1,  2, 3'd0, 32'h00001000, 1, 32'h80208063, 32'h0, 1);
        add(1, ENC_LI,     1,  0,  0, 3'd0, 32'h80000000, 1, 32'h800000B7, 32'h0, 0);

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        foreach (tbl[i]) begin
            if (i == 8) set_mode(1);
            if (tbl[i].rst) do_reset();
            send(tbl[i]);
        end
        set_mode(0);
        drain();

        // Stalled wide li: LUI must hold while the ADDI waits behind it.
        set_mode(2);
        send(tbl[1]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_instr", out_instr, 32'h123452B7);
            check("bp_addr", 32'(out_addr), 32'(exp_addr));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        set_mode(0);
        drain();
        @(negedge clk);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);

        // Reset while the LUI of a wide li is pending: the ADDI must vanish.
        set_mode(2);
        send(tbl[3]);
        @(negedge clk);
        #1;
        reset  = 1'b1;
        sticky = 1'b0;
        sb.delete();
        #1;
        check("li2_rst_valid", 32'(out_valid), 32'd0);
        check("li2_rst_addr", 32'(out_addr), 32'd0);
        check("li2_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        set_mode(0);
        stray = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        check("li2_addi_dropped", 32'(stray), 32'd0);
        @(posedge clk);
        #2;
        send(tbl[0]);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
